// File: rtl/d_branch_pkg.sv
// rtl/d_branch_pkg.sv - shared types and defaults for the decode-stage branch sequencer
package d_branch_pkg;

    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        J_NONE   = 2'b00,
        J_DIRECT = 2'b01,
        J_REG    = 2'b10
    } jump_e;

    typedef enum logic [2:0] {
        BOP_NONE = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLEZ     = 3'd3,
        BGTZ     = 3'd4,
        BLTZ     = 3'd5,
        BGEZ     = 3'd6
    } bop_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/d_branch_eval.sv
// rtl/d_branch_eval.sv - combinational branch condition, target and operand-need decode
module d_branch_eval
    import d_branch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        i_jump,
    input  logic [2:0]        i_bop,
    input  logic [ADDR_W-1:0] i_rs_data,
    input  logic [ADDR_W-1:0] i_rt_data,
    input  logic              i_rs_ready,
    input  logic              i_rt_ready,
    input  logic [ADDR_W-1:0] i_pc_plus4,
    input  logic [15:0]       i_imm16,
    input  logic [25:0]       i_jtarget,
    output logic              o_is_ctrl,
    output logic              o_ops_ready,
    output logic              o_taken,
    output logic [ADDR_W-1:0] o_target
);

    logic              need_rs;
    logic              need_rt;
    logic              rs_neg;
    logic              rs_zero;
    logic [ADDR_W-1:0] br_target;

    assign rs_neg    = i_rs_data[ADDR_W-1];
    assign rs_zero   = (i_rs_data == '0);
    assign br_target = i_pc_plus4 + {{(ADDR_W-18){i_imm16[15]}}, i_imm16, 2'b00};

    always_comb begin
        o_is_ctrl = 1'b0;
        need_rs   = 1'b0;
        need_rt   = 1'b0;
        o_taken   = 1'b0;
        o_target  = br_target;
        // Jump encodings take priority; bop is only looked at when no jump is decoded.
        if (i_jump == J_DIRECT) begin
            o_is_ctrl = 1'b1;
            o_taken   = 1'b1;
            o_target  = {i_pc_plus4[ADDR_W-1:28], i_jtarget, 2'b00};
        end else if (i_jump == J_REG) begin
            o_is_ctrl = 1'b1;
            need_rs   = 1'b1;
            o_taken   = 1'b1;
            o_target  = i_rs_data;
        end else begin
            case (i_bop)
                BEQ: begin
                    o_is_ctrl = 1'b1; need_rs = 1'b1; need_rt = 1'b1;
                    o_taken   = (i_rs_data == i_rt_data);
                end
                BNE: begin
                    o_is_ctrl = 1'b1; need_rs = 1'b1; need_rt = 1'b1;
                    o_taken   = (i_rs_data != i_rt_data);
                end
                BLEZ: begin
                    o_is_ctrl = 1'b1; need_rs = 1'b1;
                    o_taken   = rs_neg | rs_zero;
                end
                BGTZ: begin
                    o_is_ctrl = 1'b1; need_rs = 1'b1;
                    o_taken   = ~rs_neg & ~rs_zero;
                end
                BLTZ: begin
                    o_is_ctrl = 1'b1; need_rs = 1'b1;
                    o_taken   = rs_neg;
                end
                BGEZ: begin
                    o_is_ctrl = 1'b1; need_rs = 1'b1;
                    o_taken   = ~rs_neg;
                end
                default: o_is_ctrl = 1'b0;
            endcase
        end
    end

    assign o_ops_ready = (~need_rs | i_rs_ready) & (~need_rt | i_rt_ready);

endmodule

// File: rtl/d_branch_sequencer.sv
// rtl/d_branch_sequencer.sv - decode-stage branch sequencer; DELAY_SLOT_EN keeps the delay-slot instruction
module d_branch_sequencer
    import d_branch_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_dec_valid,
    input  logic [1:0]        i_jump,
    input  logic [2:0]        i_bop,
    input  logic [ADDR_W-1:0] i_rs_data,
    input  logic [ADDR_W-1:0] i_rt_data,
    input  logic              i_rs_ready,
    input  logic              i_rt_ready,
    input  logic [ADDR_W-1:0] i_pc_plus4,
    input  logic [15:0]       i_imm16,
    input  logic [25:0]       i_jtarget,
    input  logic              i_flush_ext,
    output logic              o_stall_dec,
    output logic              o_redirect,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic              o_flush_if,
    output logic              o_wait_err
);

`ifdef DELAY_SLOT_EN
    localparam logic FLUSH_ON_TAKEN = 1'b0;
`else
    localparam logic FLUSH_ON_TAKEN = 1'b1;
`endif

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic              wait_err_q, wait_err_d;
    logic              stall;
    logic              take;
    logic              is_ctrl, ops_ready, taken;
    logic [ADDR_W-1:0] target;

    d_branch_eval #(.ADDR_W(ADDR_W)) u_eval (
        .i_jump     (i_jump),
        .i_bop      (i_bop),
        .i_rs_data  (i_rs_data),
        .i_rt_data  (i_rt_data),
        .i_rs_ready (i_rs_ready),
        .i_rt_ready (i_rt_ready),
        .i_pc_plus4 (i_pc_plus4),
        .i_imm16    (i_imm16),
        .i_jtarget  (i_jtarget),
        .o_is_ctrl  (is_ctrl),
        .o_ops_ready(ops_ready),
        .o_taken    (taken),
        .o_target   (target)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        flush_d       = 1'b0;
        wait_err_d    = wait_err_q;
        stall         = 1'b0;
        take          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_dec_valid && is_ctrl) begin
                    if (ops_ready) begin
                        take = taken;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT_OPS;
                        cnt_d   = 4'd1;
                    end
                end
            end
            WAIT_OPS: begin
                if (ops_ready) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                    take    = taken;
                end else if (cnt_q == 4'(MAX_WAIT)) begin
                    // Give up: let decode advance and treat the branch as not taken.
                    wait_err_d = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (take) begin
            redirect_d    = 1'b1;
            redirect_pc_d = target;
            flush_d       = FLUSH_ON_TAKEN;
            state_d       = REDIRECT;
        end
        if (i_flush_ext) begin
            state_d       = IDLE;
            cnt_d         = 4'd0;
            redirect_d    = 1'b0;
            redirect_pc_d = redirect_pc_q;
            flush_d       = 1'b0;
            stall         = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            wait_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            wait_err_q    <= wait_err_d;
        end
    end

    // Stall is combinational, so it is gated by reset to keep all outputs low during reset.
    assign o_stall_dec   = stall & i_rst_n;
    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
    assign o_flush_if    = flush_q;
    assign o_wait_err    = wait_err_q;

endmodule
